// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC holder, imem fetch and R/I/J field split with valid/ready output
module instruction_fetch #(
    parameter int          WORD_SIZE = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] instr,
    output logic [5:0]           opcode,
    output logic [4:0]           rtype_rs,
    output logic [4:0]           rtype_rt,
    output logic [4:0]           rtype_rd,
    output logic [4:0]           rtype_shamt,
    output logic [5:0]           rtype_funct,
    output logic [4:0]           itype_rs,
    output logic [4:0]           itype_rt,
    output logic [15:0]          itype_immediate,
    output logic [25:0]          jtype_addres
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    logic [1:0]           state;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] fetch_addr;
    logic [WORD_SIZE-1:0] target;
    logic [WORD_SIZE-1:0] instr_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] redir_aligned;
    logic [WORD_SIZE-1:0] seq_next;
    logic                 unused_redirect_lsbs;

    assign redir_aligned        = {redirect_pc[WORD_SIZE-1:2], 2'b00};
    assign seq_next             = pc_q + 32'd4;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Fetch control: request stays up from assertion until ack, redirects beat sequential PC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            fetch_addr <= '0;
            target     <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (redirect_valid) begin
                        fetch_addr <= redir_aligned;
                        pc         <= redir_aligned;
                    end else begin
                        fetch_addr <= pc;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            // Wrong-path word returned: drop it and refetch at the target.
                            fetch_addr <= redir_aligned;
                            pc         <= redir_aligned;
                        end else begin
                            instr_q <= imem_rdata;
                            pc_q    <= fetch_addr;
                            state   <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Request cannot be withdrawn; remember target until the ack drains.
                        target <= redir_aligned;
                        state  <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state <= FETCH;
                        if (redirect_valid) begin
                            fetch_addr <= redir_aligned;
                            pc         <= redir_aligned;
                        end else begin
                            fetch_addr <= target;
                            pc         <= target;
                        end
                    end else if (redirect_valid) begin
                        target <= redir_aligned;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        // Either completes the transfer or drops the held word; both refetch at target.
                        fetch_addr <= redir_aligned;
                        pc         <= redir_aligned;
                        state      <= FETCH;
                    end else if (out_ready) begin
                        fetch_addr <= seq_next;
                        pc         <= seq_next;
                        state      <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_req  = (state == FETCH) || (state == DISCARD);
    assign imem_addr = fetch_addr;
    assign out_valid = (state == HOLD);
    assign pc_out    = pc_q;
    assign instr     = instr_q;

    assign opcode          = instr_q[31:26];
    assign rtype_rs        = instr_q[25:21];
    assign rtype_rt        = instr_q[20:16];
    assign rtype_rd        = instr_q[15:11];
    assign rtype_shamt     = instr_q[10:6];
    assign rtype_funct     = instr_q[5:0];
    assign itype_rs        = instr_q[25:21];
    assign itype_rt        = instr_q[20:16];
    assign itype_immediate = instr_q[15:0];
    assign jtype_addres    = instr_q[25:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rtype_rs, rtype_rt, rtype_rd, rtype_shamt;
    logic [5:0]  rtype_funct;
    logic [4:0]  itype_rs, itype_rt;
    logic [15:0] itype_immediate;
    logic [25:0] jtype_addres;

    logic auto_ack;
    logic manual_ack;
    int   errors;
    int   checks;

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .pc_out         (pc_out),
        .instr          (instr),
        .opcode         (opcode),
        .rtype_rs       (rtype_rs),
        .rtype_rt       (rtype_rt),
        .rtype_rd       (rtype_rd),
        .rtype_shamt    (rtype_shamt),
        .rtype_funct    (rtype_funct),
        .itype_rs       (itype_rs),
        .itype_rt       (itype_rt),
        .itype_immediate(itype_immediate),
        .jtype_addres   (jtype_addres)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: fixed words at 0x0 and 0x4, otherwise the inverted address.
    assign imem_rdata = (imem_addr == 32'h0) ? 32'h012A_4020 :
                        (imem_addr == 32'h4) ? 32'h2108_FFFF : ~imem_addr;
    assign imem_ack   = auto_ack ? imem_req : manual_ack;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        auto_ack = 1'b0; manual_ack = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || out_valid !== 1'b0 || pc_out !== 32'h0 ||
            instr !== 32'h0 || opcode !== 6'h0 || itype_immediate !== 16'h0 || jtype_addres !== 26'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h valid=%b pc=%h instr=%h required all zero",
                     imem_req, imem_addr, out_valid, pc_out, instr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_word [3];
        exp_word[0] = 32'h012A_4020; exp_word[1] = 32'h2108_FFFF; exp_word[2] = 32'hFFFF_FFF7;
        do_reset();
        auto_ack = 1'b1; out_ready = 1'b1; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_req%0d: req=%b addr=%h valid=%b required 1 %h 0",
                         i, imem_req, imem_addr, out_valid, 32'(4 * i));
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'(4 * i) || instr !== exp_word[i]) begin
                errors++;
                $display("FAIL seq_out%0d: valid=%b req=%b pc=%h instr=%h required 1 0 %h %h",
                         i, out_valid, imem_req, pc_out, instr, 32'(4 * i), exp_word[i]);
            end
            if (i == 0) begin
                checks++;
                if (opcode !== 6'd0 || rtype_rs !== 5'd9 || rtype_rt !== 5'd10 || rtype_rd !== 5'd8 ||
                    rtype_shamt !== 5'd0 || rtype_funct !== 6'h20) begin
                    errors++;
                    $display("FAIL rtype_decode: op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h required 0 9 10 8 0 20",
                             opcode, rtype_rs, rtype_rt, rtype_rd, rtype_shamt, rtype_funct);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        auto_ack = 1'b1; out_ready = 1'b0; rst_n = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h4;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL idle_redirect: req=%b addr=%h required 1 00000004", imem_req, imem_addr);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'h4 || instr !== 32'h2108_FFFF ||
                opcode !== 6'h08 || itype_immediate !== 16'hFFFF || itype_rs !== 5'd8 || itype_rt !== 5'd8) begin
                errors++;
                $display("FAIL stall%0d: valid=%b req=%b pc=%h instr=%h op=%h imm=%h required 1 0 4 2108ffff 08 ffff",
                         i, out_valid, imem_req, pc_out, instr, opcode, itype_immediate);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL stall_release: valid=%b req=%b addr=%h required 0 1 00000008", out_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_fetch();
        do_reset();
        out_ready = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL discard_hold%0d: req=%b addr=%h valid=%b required 1 0 0", i, imem_req, imem_addr, out_valid);
            end
            if (i == 2) manual_ack = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        manual_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL discard_refetch: valid=%b req=%b addr=%h required 0 1 00000100", out_valid, imem_req, imem_addr);
        end
        auto_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || pc_out !== 32'h100 || instr !== 32'hFFFF_FEFF) begin
            errors++;
            $display("FAIL redirect_word: valid=%b pc=%h instr=%h required 1 00000100 fffffeff", out_valid, pc_out, instr);
        end
    endtask

    task automatic test_redirect_hold_and_wrap();
        do_reset();
        auto_ack = 1'b1; out_ready = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL hold_redirect: valid=%b req=%b addr=%h required 0 1 00000200", out_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || pc_out !== 32'h200 || instr !== 32'hFFFF_FDFF) begin
            errors++;
            $display("FAIL hold_refetch: valid=%b pc=%h instr=%h required 1 00000200 fffffdff", out_valid, pc_out, instr);
        end
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        out_ready = 1'b0; redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL ready_redirect: valid=%b req=%b addr=%h required 0 1 00000300", out_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC || instr !== 32'h0000_0003) begin
            errors++;
            $display("FAIL wrap_word: valid=%b pc=%h instr=%h required 1 fffffffc 00000003", out_valid, pc_out, instr);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_next: req=%b addr=%h valid=%b required 1 00000000 0", imem_req, imem_addr, out_valid);
        end
    endtask

    task automatic test_reset_in_discard();
        do_reset();
        rst_n = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0; rst_n = 1'b0; manual_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || out_valid !== 1'b0 || pc_out !== 32'h0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: req=%b addr=%h valid=%b pc=%h instr=%h required all zero",
                     imem_req, imem_addr, out_valid, pc_out, instr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart: req=%b addr=%h valid=%b required 1 00000000 0", imem_req, imem_addr, out_valid);
        end
        @(negedge clk);
        manual_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || pc_out !== 32'h0 || instr !== 32'h012A_4020) begin
            errors++;
            $display("FAIL restart_word: valid=%b pc=%h instr=%h required 1 00000000 012a4020", out_valid, pc_out, instr);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        auto_ack = 1'b0; manual_ack = 1'b0; out_ready = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_fetch();
        test_redirect_hold_and_wrap();
        test_reset_in_discard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end stage of the MIPS core. Holds the program counter, fetches 32-bit instruction words over a req/ack instruction-memory port and splits each word into R/I/J-type fields. It presents those fields to the execute/ALU stage through a valid/ready handshake. It also accepts PC redirects (branch/jump targets) and cancels any wrong-path instruction that is in flight.

## Interface
- WORD_SIZE, 32, instruction/address width; only 32 is supported.
- RESET_PC, 32'h0000_0000, address of the first fetch after reset; bits [1:0] must be 0.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request, level.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  read data valid this cycle; only meaningful while imem_req=1.
- imem_rdata  in  32  instruction word, sampled when imem_ack=1.
- redirect_valid  in  1  replace the fetch stream with redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced to 0).
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts this cycle.
- pc_out  out  32  address of the presented instruction.
- instr  out  32  raw instruction word.
- opcode  out  6  instr[31:26].
- rtype_rs / itype_rs  out  5  instr[25:21].
- rtype_rt / itype_rt  out  5  instr[20:16].
- rtype_rd  out  5  instr[15:11].
- rtype_shamt  out  5  instr[10:6].
- rtype_funct  out  6  instr[5:0].
- itype_immediate  out  16  instr[15:0].
- jtype_addres  out  26  instr[25:0].

## Operation
- FSM states:
  - IDLE: reset state, no request.
  - FETCH: imem_req=1 at fetch_addr.
  - DISCARD: imem_req=1 at the old fetch_addr; the returning data will be dropped.
  - HOLD: out_valid=1.
- Registers:
  - pc: next fetch address, reset RESET_PC.
  - fetch_addr: address currently requested.
  - instr_q and pc_q: presented instruction and its address.
  - state.
- IDLE -> FETCH unconditionally on the first cycle with rst_n=1. fetch_addr <= pc, or <= redirect_pc if redirect_valid is high that cycle.
- FETCH, imem_ack=1, no redirect: instr_q <= imem_rdata, pc_q <= fetch_addr, go to HOLD.
- FETCH, imem_ack=1 and redirect_valid=1: discard the data, fetch_addr <= redirect_pc, stay in FETCH.
- FETCH, no ack, redirect_valid=1: target <= redirect_pc, go to DISCARD. imem_addr stays unchanged; the request is never withdrawn before ack.
- DISCARD: a further redirect_valid overwrites target (last one wins). On imem_ack the data is dropped, fetch_addr <= target (or redirect_pc if redirect_valid is high in the same cycle), go to FETCH.
- HOLD, out_ready=1: transfer completes. fetch_addr <= pc_q+4, or redirect_pc if redirect_valid=1 that cycle. Go to FETCH.
- HOLD, out_ready=0, redirect_valid=1: the held instruction is dropped, out_valid=0 next cycle. fetch_addr <= redirect_pc, go to FETCH.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No alignment exceptions.
- Decode fields are pure bit slices of instr_q with no interpretation. They are valid only when out_valid=1 and are held stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n low at a rising edge): state=IDLE. All outputs 0, including imem_req, imem_addr, out_valid, pc_out, instr and every decode field. pc=RESET_PC.
- Reset mid-operation wins over everything. An in-flight memory ack is ignored; the memory side must tolerate imem_req dropping on reset.
- imem_req/imem_addr are registered. They rise the cycle after the first edge with rst_n=1.
- Fetch latency:
  - ack in cycle N (same cycle as request allowed) -> out_valid=1 in cycle N+1.
  - Handshake in cycle M -> next imem_req in cycle M+1.
  - Best-case throughput is one instruction per 2 cycles.
- Handshake rules:
  - out_valid never drops without a transfer, except on redirect or reset.
  - imem_req and imem_addr are held stable from assertion until ack.
- Redirect has priority over the sequential PC in every state. A redirect never produces an out_valid for a wrong-path word.

## Test plan
- Reset then sequential fetch, memory acking in the request cycle, out_ready=1 throughout:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - out_valid every other cycle.
  - pc_out matches imem_addr.
  - Word 0x012A4020 decodes to opcode=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20.
- Backpressure, out_ready=0 for 5 cycles with word 0x2108FFFF: all outputs stable (opcode=0x08, immediate=0xFFFF). No new imem_req until out_ready=1.
- Redirect to 0x100 while in FETCH with ack delayed 3 cycles: imem_addr stays at the old address until ack, the data is discarded, the next request is to 0x100, and no out_valid for the old word.
- Redirect to 0x203 in HOLD with out_ready=0: the held instruction disappears next cycle and the next fetch is at 0x200. Redirect and out_ready=1 in the same cycle: exactly one transfer, next fetch at the redirect target.
- Wrap-around: redirect to 0xFFFFFFFC, then an accepted instruction leads to a next fetch at 0x00000000.
- rst_n low for one cycle during DISCARD with ack pending: all outputs 0. Fetch restarts at RESET_PC and the stale ack is ignored.
